// File: rtl/rom_download_router.sv
// rtl/rom_download_router.sv - routes ioctl ROM download bytes into four board ROM regions via a buffered req/ack write port
//
// Ports:
//   clk_sys, reset_n             clock and synchronous active-low reset
//   ioctl_download/index/wr/addr/dout   download byte stream from hps_io
//   ioctl_wait                   registered backpressure to hps_io
//   rom_init                     high while a download is loading or draining
//   mem_req/mem_ack              write handshake; mem_sel/mem_addr/mem_data valid with mem_req
//   load_done                    one-cycle pulse once the download has fully drained
//   byte_count/checksum/overflow_err   statistics of the current (or last) download

module rom_download_router #(
    parameter logic [7:0]  ROM_INDEX  = 8'd0,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [24:0] R1_BASE    = 25'h0A000,
    parameter logic [24:0] R2_BASE    = 25'h12000,
    parameter logic [24:0] R3_BASE    = 25'h1A000,
    parameter logic [24:0] ROM_END    = 25'h22000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic        rom_init,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [3:0]  mem_sel,
    output logic [16:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        load_done,
    output logic [24:0] byte_count,
    output logic [15:0] checksum,
    output logic        overflow_err
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_M1 = CW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

    state_t         state, state_next;
    logic           pending, pending_next;
    logic           match, match_d, match_rise;
    logic           accept, push_need, full, push, pop;
    logic [3:0]     dec_sel;
    logic [16:0]    dec_off;
    logic [28:0]    fifo_mem [FIFO_DEPTH];
    logic [28:0]    head;
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count, count_next;
    logic           mem_req_next;
    logic [24:0]    bc_base;
    logic [15:0]    cs_base;
    logic           ov_base;

    assign match      = ioctl_download && (ioctl_index == ROM_INDEX);
    assign match_rise = match && !match_d;
    assign accept     = match && ioctl_wr;
    assign push_need  = accept && (ioctl_addr < ROM_END);
    assign full       = (count == DEPTH_C);
    assign push       = push_need && !full;
    assign pop        = mem_req && mem_ack;

    // Offsets are computed in 17 bits directly; modular subtraction gives the truncated result.
    always_comb begin
        dec_sel = 4'b0001;
        dec_off = ioctl_addr[16:0];
        if (ioctl_addr < R1_BASE) begin
            dec_sel = 4'b0001;
            dec_off = ioctl_addr[16:0];
        end else if (ioctl_addr < R2_BASE) begin
            dec_sel = 4'b0010;
            dec_off = ioctl_addr[16:0] - R1_BASE[16:0];
        end else if (ioctl_addr < R3_BASE) begin
            dec_sel = 4'b0100;
            dec_off = ioctl_addr[16:0] - R2_BASE[16:0];
        end else begin
            dec_sel = 4'b1000;
            dec_off = ioctl_addr[16:0] - R3_BASE[16:0];
        end
    end

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (!push && pop) begin
            count_next = count - CW'(1);
        end
    end

    // A fresh request waits one cycle after the FIFO becomes non-empty; an
    // acked request continues straight into the next entry if one remains.
    assign mem_req_next = mem_req ? (count_next != '0) : (count != '0);

    // The head entry stays in the FIFO until acked, so outputs are stable while mem_req waits.
    assign head     = fifo_mem[rd_ptr];
    assign mem_sel  = mem_req ? head[28:25] : 4'b0000;
    assign mem_addr = mem_req ? head[24:8]  : 17'd0;
    assign mem_data = mem_req ? head[7:0]   : 8'd0;

    // Statistics restart on the rising edge of match, including a byte accepted in that same cycle.
    assign bc_base = match_rise ? 25'd0 : byte_count;
    assign cs_base = match_rise ? 16'd0 : checksum;
    assign ov_base = match_rise ? 1'b0  : overflow_err;

    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {dec_sel, dec_off, ioctl_dout};
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            match_d      <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            mem_req      <= 1'b0;
            ioctl_wait   <= 1'b0;
            byte_count   <= '0;
            checksum     <= '0;
            overflow_err <= 1'b0;
            state        <= IDLE;
            pending      <= 1'b0;
        end else begin
            match_d      <= match;
            wr_ptr       <= push ? wr_ptr + PW'(1) : wr_ptr;
            rd_ptr       <= pop  ? rd_ptr + PW'(1) : rd_ptr;
            count        <= count_next;
            mem_req      <= mem_req_next;
            // One slot of slack covers a strobe hps_io already has in flight.
            ioctl_wait   <= (count_next >= DEPTH_M1);
            byte_count   <= accept ? bc_base + 25'd1 : bc_base;
            checksum     <= accept ? cs_base + {8'd0, ioctl_dout} : cs_base;
            overflow_err <= ov_base | (push_need && full);
            state        <= state_next;
            pending      <= pending_next;
        end
    end

    // A download starting during FLUSH/DONE is remembered and launched from IDLE.
    always_comb begin
        state_next   = state;
        pending_next = pending;
        rom_init     = 1'b0;
        load_done    = 1'b0;
        case (state)
            IDLE: begin
                if (match_rise || pending) begin
                    state_next   = LOAD;
                    pending_next = 1'b0;
                end
            end
            LOAD: begin
                rom_init = 1'b1;
                if (!match) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                rom_init = 1'b1;
                if (match_rise) begin
                    pending_next = 1'b1;
                end
                if ((count == '0) && !mem_req) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                load_done = 1'b1;
                if (match_rise) begin
                    pending_next = 1'b1;
                end
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rom_download_router.sv
// tb/tb_rom_download_router.sv - directed self-checking bench for rom_download_router

module tb_rom_download_router;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        rom_init;
    logic        mem_req;
    logic        mem_ack;
    logic [3:0]  mem_sel;
    logic [16:0] mem_addr;
    logic [7:0]  mem_data;
    logic        load_done;
    logic [24:0] byte_count;
    logic [15:0] checksum;
    logic        overflow_err;

    int checks   = 0;
    int failures = 0;

    logic [3:0]  log_sel  [$];
    logic [16:0] log_addr [$];
    logic [7:0]  log_data [$];
    int          done_n = 0;

    always #5 clk_sys = ~clk_sys;

    rom_download_router dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .rom_init       (rom_init),
        .mem_req        (mem_req),
        .mem_ack        (mem_ack),
        .mem_sel        (mem_sel),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .load_done      (load_done),
        .byte_count     (byte_count),
        .checksum       (checksum),
        .overflow_err   (overflow_err)
    );

    // Records every write that will be committed at the next rising edge.
    always begin
        @(negedge clk_sys);
        #2;
        if (reset_n && mem_req && mem_ack) begin
            log_sel.push_back(mem_sel);
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_data);
        end
        if (reset_n && load_done) begin
            done_n++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk_sys);
    endtask

    task automatic write_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            tick();
            if (done_n != d0) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        bit bad;
        ioctl_index    = 8'd0;
        mem_ack        = 1'b0;
        ioctl_download = 1'b1;
        tick();
        write_byte(25'h00010, 8'hA5);
        write_byte(25'h0A010, 8'h5A);
        tick();
        checks++;
        if (mem_req !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre_req: mem_req=%b want 1", mem_req);
        end
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        repeat (3) tick();
        checks++;
        if ({ioctl_wait, rom_init, mem_req, mem_sel, mem_addr, mem_data, load_done,
             byte_count, checksum, overflow_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: wait=%b init=%b req=%b sel=%b addr=%h data=%h done=%b bc=%0d cs=%h ov=%b want all 0",
                     ioctl_wait, rom_init, mem_req, mem_sel, mem_addr, mem_data, load_done,
                     byte_count, checksum, overflow_err);
        end
        reset_n = 1'b1;
        bad = 1'b0;
        repeat (5) begin
            tick();
            if (mem_req !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL reset_release_req: mem_req went %b want 0", 1'b1);
        end
    endtask

    task automatic test_region_decode();
        logic [3:0]  es [4];
        logic [16:0] ea [4];
        logic [7:0]  ed [4];
        int b;
        int d0;
        bit seen;
        es = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        ea = '{17'd0, 17'd1, 17'd2, 17'd3};
        ed = '{8'h11, 8'h22, 8'h33, 8'h44};
        b  = log_sel.size();
        d0 = done_n;
        mem_ack        = 1'b1;
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        checks++;
        if (rom_init !== 1'b0) begin
            failures++;
            $display("FAIL region_init_before: rom_init=%b want 0", rom_init);
        end
        tick();
        checks++;
        if (rom_init !== 1'b1) begin
            failures++;
            $display("FAIL region_init_rise: rom_init=%b want 1", rom_init);
        end
        write_byte(25'h00000, 8'h11);
        write_byte(25'h0A001, 8'h22);
        write_byte(25'h12002, 8'h33);
        write_byte(25'h1A003, 8'h44);
        write_byte(25'h22000, 8'h55);
        ioctl_download = 1'b0;
        wait_done(d0, 60, seen);
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL region_done_timeout: load_done seen=%b want 1", seen);
        end
        repeat (3) tick();
        checks++;
        if (done_n - d0 != 1) begin
            failures++;
            $display("FAIL region_done_pulses: got %0d want 1", done_n - d0);
        end
        checks++;
        if (log_sel.size() - b != 4) begin
            failures++;
            $display("FAIL region_write_count: got %0d want 4", log_sel.size() - b);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (b + i >= log_sel.size()) begin
                failures++;
                $display("FAIL region_write%0d: missing want sel=%b addr=%0d data=%h", i, es[i], ea[i], ed[i]);
            end else if (log_sel[b+i] !== es[i] || log_addr[b+i] !== ea[i] || log_data[b+i] !== ed[i]) begin
                failures++;
                $display("FAIL region_write%0d: got sel=%b addr=%0d data=%h want sel=%b addr=%0d data=%h",
                         i, log_sel[b+i], log_addr[b+i], log_data[b+i], es[i], ea[i], ed[i]);
            end
        end
        checks++;
        if (byte_count !== 25'd5 || checksum !== 16'h00FF) begin
            failures++;
            $display("FAIL region_stats: bc=%0d cs=%h want bc=5 cs=00ff", byte_count, checksum);
        end
    endtask

    task automatic test_backpressure();
        logic ew [4];
        int b;
        int d0;
        bit seen;
        ew = '{1'b0, 1'b0, 1'b1, 1'b1};
        mem_ack        = 1'b0;
        ioctl_download = 1'b1;
        tick();
        b  = log_sel.size();
        d0 = done_n;
        for (int i = 0; i < 4; i++) begin
            write_byte(25'h12000 + 25'(i), 8'h60 + 8'(i));
            checks++;
            if (ioctl_wait !== ew[i]) begin
                failures++;
                $display("FAIL bp_wait_after_byte%0d: ioctl_wait=%b want %b", i + 1, ioctl_wait, ew[i]);
            end
        end
        checks++;
        if (overflow_err !== 1'b0) begin
            failures++;
            $display("FAIL bp_overflow: overflow_err=%b want 0", overflow_err);
        end
        ioctl_download = 1'b0;
        mem_ack        = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem_req !== 1'b1) begin
                failures++;
                $display("FAIL bp_req_gap%0d: mem_req=%b want 1", i, mem_req);
            end
            tick();
        end
        checks++;
        if (mem_req !== 1'b0) begin
            failures++;
            $display("FAIL bp_req_end: mem_req=%b want 0", mem_req);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (b + i >= log_sel.size()) begin
                failures++;
                $display("FAIL bp_write%0d: missing want addr=%0d", i, i);
            end else if (log_sel[b+i] !== 4'b0100 || log_addr[b+i] !== 17'(i) || log_data[b+i] !== 8'h60 + 8'(i)) begin
                failures++;
                $display("FAIL bp_write%0d: got sel=%b addr=%0d data=%h want sel=0100 addr=%0d data=%h",
                         i, log_sel[b+i], log_addr[b+i], log_data[b+i], i, 8'h60 + 8'(i));
            end
        end
        wait_done(d0, 40, seen);
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL bp_done_timeout: load_done seen=%b want 1", seen);
        end
    endtask

    task automatic test_overflow();
        int b;
        int d0;
        bit seen;
        mem_ack        = 1'b0;
        ioctl_download = 1'b1;
        tick();
        b  = log_sel.size();
        d0 = done_n;
        for (int i = 0; i < 6; i++) begin
            write_byte(25'h00100 + 25'(i), 8'(i + 1));
        end
        checks++;
        if (overflow_err !== 1'b1 || byte_count !== 25'd6 || checksum !== 16'h0015) begin
            failures++;
            $display("FAIL ovf_stats: ov=%b bc=%0d cs=%h want ov=1 bc=6 cs=0015", overflow_err, byte_count, checksum);
        end
        ioctl_download = 1'b0;
        mem_ack        = 1'b1;
        wait_done(d0, 40, seen);
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL ovf_done_timeout: load_done seen=%b want 1", seen);
        end
        checks++;
        if (log_sel.size() - b != 4) begin
            failures++;
            $display("FAIL ovf_write_count: got %0d want 4", log_sel.size() - b);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (b + i >= log_sel.size()) begin
                failures++;
                $display("FAIL ovf_write%0d: missing want data=%0d", i, i + 1);
            end else if (log_sel[b+i] !== 4'b0001 || log_addr[b+i] !== 17'h100 + 17'(i) || log_data[b+i] !== 8'(i + 1)) begin
                failures++;
                $display("FAIL ovf_write%0d: got sel=%b addr=%h data=%h want sel=0001 addr=%h data=%h",
                         i, log_sel[b+i], log_addr[b+i], log_data[b+i], 17'h100 + 17'(i), 8'(i + 1));
            end
        end
    endtask

    task automatic test_index_filter();
        logic [7:0] idx [2];
        int b;
        int d0;
        bit init_seen;
        idx = '{8'd1, 8'd254};
        mem_ack = 1'b1;
        for (int k = 0; k < 2; k++) begin
            b  = log_sel.size();
            d0 = done_n;
            init_seen      = 1'b0;
            ioctl_index    = idx[k];
            ioctl_download = 1'b1;
            tick();
            for (int i = 0; i < 3; i++) begin
                write_byte(25'h00200 + 25'(i), 8'hC0 + 8'(i));
                if (rom_init !== 1'b0) init_seen = 1'b1;
            end
            ioctl_download = 1'b0;
            repeat (5) begin
                tick();
                if (rom_init !== 1'b0) init_seen = 1'b1;
            end
            checks++;
            if (log_sel.size() != b || done_n != d0 || init_seen) begin
                failures++;
                $display("FAIL idx%0d_ignored: writes=%0d dones=%0d rom_init_seen=%b want 0 0 0",
                         idx[k], log_sel.size() - b, done_n - d0, init_seen);
            end
            checks++;
            if (byte_count !== 25'd6 || checksum !== 16'h0015 || overflow_err !== 1'b1) begin
                failures++;
                $display("FAIL idx%0d_stats_hold: bc=%0d cs=%h ov=%b want bc=6 cs=0015 ov=1",
                         idx[k], byte_count, checksum, overflow_err);
            end
        end
        ioctl_index = 8'd0;
    endtask

    task automatic test_checksum_wrap();
        int b;
        int d0;
        int sent;
        int guard;
        bit seen;
        mem_ack        = 1'b1;
        ioctl_download = 1'b1;
        tick();
        checks++;
        if (overflow_err !== 1'b0 || byte_count !== 25'd0 || checksum !== 16'd0) begin
            failures++;
            $display("FAIL wrap_clear: ov=%b bc=%0d cs=%h want 0 0 0000", overflow_err, byte_count, checksum);
        end
        b     = log_sel.size();
        d0    = done_n;
        sent  = 0;
        guard = 0;
        while (sent < 300 && guard < 2000) begin
            if (!ioctl_wait) begin
                write_byte(25'(sent), 8'hFF);
                sent++;
            end else begin
                tick();
            end
            guard++;
        end
        checks++;
        if (sent != 300) begin
            failures++;
            $display("FAIL wrap_sent: got %0d want 300", sent);
        end
        ioctl_download = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            if (done_n != d0) begin
                seen = 1'b1;
                checks++;
                if (log_sel.size() - b != 300) begin
                    failures++;
                    $display("FAIL wrap_done_early: writes=%0d want 300", log_sel.size() - b);
                end
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL wrap_done_timeout: load_done seen=%b want 1", seen);
        end
        checks++;
        if (byte_count !== 25'd300 || checksum !== 16'h2AD4 || overflow_err !== 1'b0) begin
            failures++;
            $display("FAIL wrap_stats: bc=%0d cs=%h ov=%b want bc=300 cs=2ad4 ov=0", byte_count, checksum, overflow_err);
        end
        checks++;
        if (log_addr.size() == 0 || log_addr[log_addr.size()-1] !== 17'd299) begin
            failures++;
            $display("FAIL wrap_last_addr: got %0d want 299",
                     log_addr.size() == 0 ? -1 : int'(log_addr[log_addr.size()-1]));
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        mem_ack        = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        test_reset();
        test_region_decode();
        test_backpressure();
        test_overflow();
        test_index_filter();
        test_checksum_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rom_download_router.md
Name: rom_download_router

Overview:
- Sits between hps_io's ioctl download stream and the board ROM/RAM write ports (mylstar_board and ma216_board).
- Accepts download bytes for the ROM index and buffers them in a small FIFO.
- Decodes each byte's address into one of four ROM regions and drains the bytes over a req/ack memory port.
- Throttles the HPS with ioctl_wait, and reports completion, byte count, checksum and overflow.

Parameters:
ROM_INDEX, 8'd0, ioctl_index value routed by this block; all other indices are ignored.
FIFO_DEPTH, 4, entries in the write buffer; power of two, >=2.
R1_BASE, 25'h0A000, first byte address of region 1; region 0 = [0, R1_BASE).
R2_BASE, 25'h12000, first byte address of region 2.
R3_BASE, 25'h1A000, first byte address of region 3.
ROM_END, 25'h22000, first address past region 3; bytes at or above it are not written.

Ports:
clk_sys  in  1  system clock; all logic on rising edge.
reset_n  in  1  synchronous reset, active-low.
ioctl_download  in  1  download active.
ioctl_index  in  8  download target index.
ioctl_wr  in  1  byte strobe, 1 cycle.
ioctl_addr  in  25  byte address.
ioctl_dout  in  8  byte data.
ioctl_wait  out  1  backpressure to hps_io.
rom_init  out  1  high from download start until all bytes are drained.
mem_req  out  1  write request to the target memory.
mem_ack  in  1  target accepted the current write (1 cycle).
mem_sel  out  4  one-hot region select, valid while mem_req is high.
mem_addr  out  17  region-relative address.
mem_data  out  8  write data.
load_done  out  1  1-cycle pulse when the download has fully drained.
byte_count  out  25  bytes accepted in the current download.
checksum  out  16  wrapping sum of accepted bytes.
overflow_err  out  1  sticky; a byte was dropped because the FIFO was full.

Behaviour:
- Reset (reset_n=0 at a clock edge) clears everything: all outputs 0, FIFO empty, FSM in IDLE.
  - Reset wins over every other event in the same cycle.
  - Reset mid-transfer abandons the outstanding request; mem_req drops the following cycle.
- "match" = ioctl_download & (ioctl_index==ROM_INDEX).
- On a rising edge of match:
  - byte_count, checksum and overflow_err clear.
  - rom_init rises next cycle.
  - FSM goes IDLE->LOAD.
- Accept condition: match & ioctl_wr.
  - Accepted byte: byte_count+=1; checksum+=zero-extended byte, mod 2^16.
  - Addresses >= ROM_END are accepted (counted, summed) but not pushed into the FIFO.
  - Otherwise {sel, offset, data} is pushed.
- Region decode:
  - addr<R1_BASE: sel=0001, offset=addr.
  - addr<R2_BASE: sel=0010, offset=addr-R1_BASE.
  - addr<R3_BASE: sel=0100, offset=addr-R2_BASE.
  - else: sel=1000, offset=addr-R3_BASE.
  - Offset is truncated to 17 bits.
- FIFO full when a push is needed: the byte is dropped, overflow_err=1, byte_count/checksum still increment.
- A push and a pop in the same cycle are legal; occupancy is unchanged.
- ioctl_wait is registered: 1 when occupancy after this cycle >= FIFO_DEPTH-1, else 0.
  - This leaves one slot of slack for a strobe already in flight.
- Drain side, independent of the FSM state:
  - When mem_req=0 and the FIFO is non-empty: present the head entry on mem_sel/addr/data and set mem_req=1 next cycle.
  - While mem_req=1, the outputs hold stable until mem_ack.
  - On mem_ack: pop. If more entries remain, the next entry is presented on the following cycle with mem_req still 1 (back-to-back writes, no gap). Otherwise mem_req=0.
  - mem_ack while mem_req=0 is ignored.
- FSM states:
  - IDLE -> LOAD on match rising.
  - LOAD -> FLUSH when match falls.
  - FLUSH -> DONE when the FIFO is empty and mem_req=0.
  - DONE lasts 1 cycle: load_done=1, rom_init=0, then IDLE.
  - A new match rising while in FLUSH is held off until DONE completes; it then takes effect in IDLE the next cycle.
- byte_count, checksum and overflow_err hold after DONE until the next download starts.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles during an active transfer -> every output is 0, and mem_req stays 0 after release with no new bytes.
- Region decode: with mem_ack tied high, write bytes 0x11@0x00000, 0x22@0x0A001, 0x33@0x12002, 0x44@0x1A003, 0x55@0x22000, then end the download. Required response:
  - Four writes in order: sel 0001/addr 0, 0010/addr 1, 0100/addr 2, 1000/addr 3.
  - Byte 0x55 is not written.
  - byte_count=5, checksum=0x00FF, one load_done pulse.
- Backpressure: with mem_ack=0, stream bytes one every cycle -> ioctl_wait=1 after the 3rd accepted byte and overflow_err stays 0 while the bench honours wait. Releasing mem_ack drains 4 writes back-to-back with no mem_req gap.
- Overflow: with mem_ack=0, ignore ioctl_wait and write 6 bytes -> overflow_err=1, exactly 4 writes drained, byte_count=6.
- Index filter: a download with ioctl_index=1 or 254 produces no mem_req, rom_init=0, no load_done, and counters keep their prior values.
- Checksum wrap: write 300 bytes of 0xFF -> checksum=0x2AD4, byte_count=300, load_done only after the 300th ack.
